// File: rtl/text_pkg.sv
// Shared definitions for the character RAM writer and reader: screen
// geometry defaults, control codes, FSM and cursor command encodings.
package text_pkg;

  localparam int DEFAULT_COLS       = 16;
  localparam int DEFAULT_ROWS       = 5;
  localparam int DEFAULT_ADDR_WIDTH = 7;
  localparam int DEFAULT_DATA_WIDTH = 8;

  localparam logic [7:0] CHAR_BLANK = 8'h20;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_FF    = 8'h0C;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CLR_ALL  = 2'd1,
    ST_CLR_LINE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CUR_NONE    = 3'd0,
    CUR_INC     = 3'd1,
    CUR_NEWLINE = 3'd2,
    CUR_BACK    = 3'd3,
    CUR_HOME    = 3'd4,
    CUR_CR      = 3'd5
  } cursor_cmd_e;

  // Codes that land on screen as a glyph rather than acting as a control.
  function automatic logic is_printable(input logic [7:0] code);
    return (code >= 8'h20) && (code <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_writer_if.sv
// Character stream handshake plus the RAM write port and cursor/status
// outputs of the text writer. The slave side is the writer itself.
interface text_writer_if
  import text_pkg::*;
#(
  parameter int addr_width = DEFAULT_ADDR_WIDTH,
  parameter int data_width = DEFAULT_DATA_WIDTH,
  parameter int col_width  = $clog2(DEFAULT_COLS),
  parameter int row_width  = $clog2(DEFAULT_ROWS)
);

  logic [data_width-1:0] char_in;
  logic                  char_valid;
  logic                  char_ready;
  logic                  write_en;
  logic [addr_width-1:0] waddr;
  logic [data_width-1:0] din;
  logic [col_width-1:0]  cursor_col;
  logic [row_width-1:0]  cursor_row;
  logic                  busy;

  modport master (
    output char_in, char_valid,
    input  char_ready, write_en, waddr, din, cursor_col, cursor_row, busy
  );

  modport slave (
    input  char_in, char_valid,
    output char_ready, write_en, waddr, din, cursor_col, cursor_row, busy
  );

endinterface

// File: rtl/text_cursor.sv
// Text cursor counters. row_base tracks row*COLS incrementally so the
// writer can form a RAM address with a single add.
module text_cursor
  import text_pkg::*;
#(
  parameter int COLS       = DEFAULT_COLS,
  parameter int ROWS       = DEFAULT_ROWS,
  parameter int addr_width = DEFAULT_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  cursor_cmd_e                cmd,
  output logic [$clog2(COLS)-1:0]    col,
  output logic [$clog2(ROWS)-1:0]    row,
  output logic [addr_width-1:0]      row_base
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam logic [ROW_W-1:0]      LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [addr_width-1:0] ROW_STEP = addr_width'(COLS);

  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [addr_width-1:0] row_base_q, row_base_d;

  // Cursor registers, homed on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
    end
  end

  // Apply one cursor command; the last row wraps to the top (no scrolling).
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    case (cmd)
      CUR_INC: col_d = col_q + 1'b1;
      CUR_NEWLINE: begin
        col_d = '0;
        if (row_q == LAST_ROW) begin
          row_d      = '0;
          row_base_d = '0;
        end else begin
          row_d      = row_q + 1'b1;
          row_base_d = row_base_q + ROW_STEP;
        end
      end
      CUR_BACK: begin
        if (col_q != '0) begin
          col_d = col_q - 1'b1;
        end
      end
      CUR_HOME: begin
        col_d      = '0;
        row_d      = '0;
        row_base_d = '0;
      end
      CUR_CR: col_d = '0;
      default: ;
    endcase
  end

  assign col      = col_q;
  assign row      = row_q;
  assign row_base = row_base_q;

endmodule

// File: rtl/text_writer.sv
// Write-side controller for the character RAM: consumes a character
// stream, interprets LF/CR/BS/FF, and drives registered RAM writes.
module text_writer
  import text_pkg::*;
#(
  parameter int                    COLS       = DEFAULT_COLS,
  parameter int                    ROWS       = DEFAULT_ROWS,
  parameter int                    addr_width = DEFAULT_ADDR_WIDTH,
  parameter int                    data_width = DEFAULT_DATA_WIDTH,
  parameter logic [data_width-1:0] BLANK      = CHAR_BLANK
) (
  input  logic          clk,
  input  logic          rst,
  text_writer_if.slave  bus
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam logic [COL_W-1:0]      LAST_COL       = COL_W'(COLS - 1);
  localparam logic [addr_width-1:0] LAST_CELL      = addr_width'(COLS * ROWS - 1);
  localparam logic [addr_width-1:0] LAST_LINE_CELL = addr_width'(COLS - 1);

  state_e                state_q, state_d;
  logic                  write_en_q, write_en_d;
  logic                  clr_wr_q, clr_wr_d;
  logic [addr_width-1:0] waddr_q, waddr_d;
  logic [data_width-1:0] din_q, din_d;
  logic [addr_width-1:0] clr_cnt_q, clr_cnt_d;

  cursor_cmd_e           cur_cmd;
  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [addr_width-1:0] row_base;
  logic [addr_width-1:0] cell_addr;
  logic                  ready;
  logic                  accept;

  text_cursor #(
    .COLS       (COLS),
    .ROWS       (ROWS),
    .addr_width (addr_width)
  ) u_cursor (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cur_cmd),
    .col      (col),
    .row      (row),
    .row_base (row_base)
  );

  assign cell_addr = row_base + addr_width'(col);
  assign ready     = (state_q == ST_IDLE);
  assign accept    = bus.char_valid & ready;

  // State and RAM-port registers; reset restarts the full-screen clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLR_ALL;
      write_en_q <= 1'b0;
      clr_wr_q   <= 1'b0;
      waddr_q    <= '0;
      din_q      <= BLANK;
      clr_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      write_en_q <= write_en_d;
      clr_wr_q   <= clr_wr_d;
      waddr_q    <= waddr_d;
      din_q      <= din_d;
      clr_cnt_q  <= clr_cnt_d;
    end
  end

  // Next state, next RAM write and the cursor command for this cycle.
  always_comb begin
    state_d    = state_q;
    write_en_d = 1'b0;
    clr_wr_d   = 1'b0;
    waddr_d    = waddr_q;
    din_d      = din_q;
    clr_cnt_d  = clr_cnt_q;
    cur_cmd    = CUR_NONE;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_printable(bus.char_in)) begin
            write_en_d = 1'b1;
            waddr_d    = cell_addr;
            din_d      = bus.char_in;
            if (col == LAST_COL) begin
              cur_cmd   = CUR_NEWLINE;
              state_d   = ST_CLR_LINE;
              clr_cnt_d = '0;
            end else begin
              cur_cmd = CUR_INC;
            end
          end else if (bus.char_in == CHAR_LF) begin
            cur_cmd   = CUR_NEWLINE;
            state_d   = ST_CLR_LINE;
            clr_cnt_d = '0;
          end else if (bus.char_in == CHAR_CR) begin
            cur_cmd = CUR_CR;
          end else if (bus.char_in == CHAR_BS) begin
            if (col != '0) begin
              cur_cmd    = CUR_BACK;
              write_en_d = 1'b1;
              waddr_d    = cell_addr - addr_width'(1);
              din_d      = BLANK;
            end
          end else if (bus.char_in == CHAR_FF) begin
            cur_cmd   = CUR_HOME;
            state_d   = ST_CLR_ALL;
            clr_cnt_d = '0;
          end
        end
      end
      ST_CLR_ALL: begin
        write_en_d = 1'b1;
        clr_wr_d   = 1'b1;
        waddr_d    = clr_cnt_q;
        din_d      = BLANK;
        if (clr_cnt_q == LAST_CELL) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
          cur_cmd   = CUR_HOME;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      ST_CLR_LINE: begin
        write_en_d = 1'b1;
        clr_wr_d   = 1'b1;
        waddr_d    = row_base + clr_cnt_q;
        din_d      = BLANK;
        if (clr_cnt_q == LAST_LINE_CELL) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // busy also covers the last registered clear write, which is still on
  // the RAM port in the first cycle the FSM is back in IDLE.
  assign bus.char_ready = ready;
  assign bus.busy       = !ready || clr_wr_q;
  assign bus.write_en   = write_en_q;
  assign bus.waddr      = waddr_q;
  assign bus.din        = din_q;
  assign bus.cursor_col = col;
  assign bus.cursor_row = row;

endmodule

// File: tb/tb_text_writer.sv
// Testbench for text_writer: directed scenarios plus random character
// traffic compared against a screen-image reference model.
module tb_text_writer;
  import text_pkg::*;

  localparam int COLS  = 16;
  localparam int ROWS  = 5;
  localparam int CELLS = COLS * ROWS;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  text_writer_if #(
    .addr_width (7),
    .data_width (8),
    .col_width  (4),
    .row_width  (3)
  ) bus ();

  text_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int check_count = 0;
  int pass_count  = 0;

  logic [7:0] dut_ram [0:127];
  int         write_count    = 0;
  int         bad_addr_count = 0;

  logic [7:0] model_ram [0:CELLS-1];
  int         model_col;
  int         model_row;
  int         model_writes;
  int         write_base;

  logic [7:0] other_codes [0:5] = '{8'h00, 8'h07, 8'h1B, 8'h7F, 8'h80, 8'hFF};

  // Capture every RAM write the DUT issues into a shadow image.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.write_en === 1'b1) begin
      if (int'(bus.waddr) >= CELLS) begin
        bad_addr_count++;
      end else begin
        dut_ram[bus.waddr] = bus.din;
      end
      write_count++;
    end
  end

  // Watchdog so the bench always ends.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed == expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelClearRow(input int r);
    for (int c = 0; c < COLS; c++) model_ram[r * COLS + c] = CHAR_BLANK;
    model_writes += COLS;
  endtask

  task automatic modelNewline();
    model_col = 0;
    model_row = (model_row + 1) % ROWS;
    modelClearRow(model_row);
  endtask

  // Screen semantics of one accepted character.
  task automatic modelChar(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      model_ram[model_row * COLS + model_col] = c;
      model_writes++;
      if (model_col == COLS - 1) modelNewline();
      else model_col++;
    end else if (c == CHAR_LF) begin
      modelNewline();
    end else if (c == CHAR_CR) begin
      model_col = 0;
    end else if (c == CHAR_BS) begin
      if (model_col > 0) begin
        model_col--;
        model_ram[model_row * COLS + model_col] = CHAR_BLANK;
        model_writes++;
      end
    end else if (c == CHAR_FF) begin
      for (int i = 0; i < CELLS; i++) model_ram[i] = CHAR_BLANK;
      model_writes += CELLS;
      model_col = 0;
      model_row = 0;
    end
  endtask

  task automatic compareModel();
    int diffs = 0;
    for (int i = 0; i < CELLS; i++) if (dut_ram[i] !== model_ram[i]) diffs++;
    checkOutput("ram_image_diffs", diffs, 0);
    checkOutput("write_count", write_count - write_base, model_writes);
    checkOutput("cursor_col", int'(bus.cursor_col), model_col);
    checkOutput("cursor_row", int'(bus.cursor_row), model_row);
  endtask

  // Reset, check the reset state, then check the full-screen sweep.
  task automatic applyReset();
    int n;
    int errs;
    bus.char_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_write_en", int'(bus.write_en), 0);
    checkOutput("rst_waddr", int'(bus.waddr), 0);
    checkOutput("rst_din", int'(bus.din), 32'h20);
    checkOutput("rst_col", int'(bus.cursor_col), 0);
    checkOutput("rst_row", int'(bus.cursor_row), 0);
    checkOutput("rst_ready", int'(bus.char_ready), 0);
    checkOutput("rst_busy", int'(bus.busy), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    @(negedge clk);
    while (bus.write_en !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("sweep_start", int'(bus.write_en), 1);
    errs = 0;
    for (int i = 0; i < CELLS; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.write_en !== 1'b1 || int'(bus.waddr) != i || bus.din !== 8'h20 || bus.busy !== 1'b1)
        errs++;
      if (i < CELLS - 1 && bus.char_ready !== 1'b0) errs++;
    end
    checkOutput("sweep_sequence_errors", errs, 0);
    @(negedge clk);
    checkOutput("sweep_done_ready", int'(bus.char_ready), 1);
    checkOutput("sweep_done_busy", int'(bus.busy), 0);
    checkOutput("sweep_done_write_en", int'(bus.write_en), 0);
    #1;
    for (int i = 0; i < CELLS; i++) model_ram[i] = CHAR_BLANK;
    model_col    = 0;
    model_row    = 0;
    model_writes = 0;
    write_base   = write_count;
  endtask

  // Send one character after a random idle gap, wait for the block to be
  // ready again, and compare against the model. low_cycles counts the
  // cycles char_ready stayed low after the accept.
  task automatic applyStimulus(input logic [7:0] c, output int low_cycles);
    int gap = $urandom_range(0, 2);
    repeat (gap) begin
      @(posedge clk);
      #1 bus.char_in = 8'($urandom);
    end
    @(negedge clk);
    checkOutput("ready_before_send", int'(bus.char_ready), 1);
    bus.char_in    = c;
    bus.char_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.char_valid = 1'b0;
    bus.char_in    = 8'($urandom);
    modelChar(c);
    low_cycles = 0;
    @(negedge clk);
    #1;
    while (bus.char_ready !== 1'b1 && low_cycles < 200) begin
      low_cycles++;
      @(negedge clk);
      #1;
    end
    checkOutput("ready_return", int'(bus.char_ready), 1);
    compareModel();
  endtask

  function automatic logic [7:0] randomChar();
    int r = $urandom_range(0, 99);
    if (r < 70) return 8'($urandom_range(32'h20, 32'h7E));
    if (r < 78) return CHAR_LF;
    if (r < 84) return CHAR_CR;
    if (r < 92) return CHAR_BS;
    if (r < 94) return CHAR_FF;
    return other_codes[$urandom_range(0, 5)];
  endfunction

  initial begin
    int low;
    int wb;
    rst            = 1'b1;
    bus.char_valid = 1'b0;
    bus.char_in    = 8'h00;
    model_col      = 0;
    model_row      = 0;
    model_writes   = 0;
    write_base     = 0;

    $display("[TB] reset and full clear");
    applyReset();

    $display("[TB] AB");
    applyStimulus(8'h41, low);
    applyStimulus(8'h42, low);
    checkOutput("ab_cell0", int'(dut_ram[0]), 32'h41);
    checkOutput("ab_cell1", int'(dut_ram[1]), 32'h42);
    checkOutput("ab_col", int'(bus.cursor_col), 2);

    $display("[TB] line wrap");
    applyStimulus(CHAR_CR, low);
    for (int i = 0; i < COLS; i++) applyStimulus(8'h58, low);
    checkOutput("wrap_ready_low_cycles", low, 16);
    checkOutput("wrap_cell15", int'(dut_ram[15]), 32'h58);
    checkOutput("wrap_row", int'(bus.cursor_row), 1);

    $display("[TB] LF wrap from last row");
    for (int i = 0; i < 3; i++) applyStimulus(CHAR_LF, low);
    checkOutput("lf_at_row4", int'(bus.cursor_row), 4);
    applyStimulus(CHAR_LF, low);
    checkOutput("lf_wrap_row", int'(bus.cursor_row), 0);
    checkOutput("lf_wrap_cell0", int'(dut_ram[0]), 32'h20);

    $display("[TB] backspace");
    applyStimulus(8'h41, low);
    applyStimulus(CHAR_BS, low);
    checkOutput("bs_cell0", int'(dut_ram[0]), 32'h20);
    wb = write_count;
    applyStimulus(CHAR_BS, low);
    checkOutput("bs_col0_no_write", write_count - wb, 0);

    $display("[TB] reset during line clear");
    @(negedge clk);
    bus.char_in    = CHAR_LF;
    bus.char_valid = 1'b1;
    @(posedge clk);
    #1 bus.char_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("mid_clear_busy", int'(bus.busy), 1);
    applyReset();

    $display("[TB] random traffic");
    for (int i = 0; i < 200; i++) applyStimulus(randomChar(), low);

    checkOutput("bad_addr_writes", bad_addr_count, 0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
